// File: rtl/alu_rs_pkg.sv
//============================================================================
// Module      : alu_rs_pkg
// Description : Shared configuration, operand/entry types and CDB snoop helper
//               for the ALU reservation station.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package alu_rs_pkg;

    localparam int RS_SIZE        = 8;
    localparam int RS_IDX_W       = 3;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int XLEN           = 32;
    localparam int OP_W           = 5;
    localparam int OP_BRANCH_BIT  = 4;
    localparam int OP_ALT_BIT     = 3;
    localparam int FUNCT3_W       = 3;

    typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;

    typedef struct packed {
        logic            busy;
        rob_tag_t        tag;
        logic [XLEN-1:0] value;
    } operand_t;

    typedef struct packed {
        logic            busy;
        logic [OP_W-1:0] op;
        rob_tag_t        rob_id;
        operand_t        src1;
        operand_t        src2;
    } rs_entry_t;

    // ALU bus is tested first so it wins when both buses carry the same tag.
    function automatic operand_t snoop(
        input operand_t        cur,
        input logic            alu_v,
        input rob_tag_t        alu_tag,
        input logic [XLEN-1:0] alu_val,
        input logic            lsb_v,
        input rob_tag_t        lsb_tag,
        input logic [XLEN-1:0] lsb_val
    );
        operand_t res;
        res = cur;
        if (cur.busy && alu_v && (alu_tag == cur.tag)) begin
            res.value = alu_val;
            res.busy  = 1'b0;
        end else if (cur.busy && lsb_v && (lsb_tag == cur.tag)) begin
            res.value = lsb_val;
            res.busy  = 1'b0;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rs_if.sv
//============================================================================
// Module      : alu_rs_if
// Description : Dispatch, result-broadcast and ALU-issue bundle of the
//               ALU reservation station.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface alu_rs_if;
    import alu_rs_pkg::*;

    logic                     disp_valid;
    logic [OP_W-1:0]          disp_op;
    logic [ROB_SIZE_WIDTH-1:0] disp_rob_id;
    logic [XLEN-1:0]          disp_v1;
    logic [XLEN-1:0]          disp_v2;
    logic                     disp_q1_busy;
    logic                     disp_q2_busy;
    logic [ROB_SIZE_WIDTH-1:0] disp_q1;
    logic [ROB_SIZE_WIDTH-1:0] disp_q2;

    logic                     cdb_alu_valid;
    logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id;
    logic [XLEN-1:0]          cdb_alu_value;
    logic                     cdb_lsb_valid;
    logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id;
    logic [XLEN-1:0]          cdb_lsb_value;

    logic                     rs_full;
    logic                     alu_valid;
    logic [OP_W-1:0]          alu_op;
    logic [XLEN-1:0]          alu_v1;
    logic [XLEN-1:0]          alu_v2;
    logic [ROB_SIZE_WIDTH-1:0] alu_rob_id;

    modport master (
        output disp_valid, disp_op, disp_rob_id, disp_v1, disp_v2,
               disp_q1_busy, disp_q2_busy, disp_q1, disp_q2,
               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
        input  rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
    );

    modport slave (
        input  disp_valid, disp_op, disp_rob_id, disp_v1, disp_v2,
               disp_q1_busy, disp_q2_busy, disp_q1, disp_q2,
               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
        output rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
    );

endinterface

`default_nettype wire

// File: rtl/alu_rs_select.sv
//============================================================================
// Module      : alu_rs_select
// Description : Combinational lowest-index priority encoder.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_rs_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  wire logic [N-1:0] req,
    output logic              found,
    output logic [W-1:0]      idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
//============================================================================
// Module      : alu_rs
// Description : ALU reservation station: holds dispatched ops until operands
//               are woken by the CDBs, issues the lowest ready slot per cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_rs
    import alu_rs_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic rdy,
    input  wire logic clear,
    alu_rs_if.slave   bus
);

    rs_entry_t               r_entries [RS_SIZE];
    logic                    r_alu_valid;
    logic [OP_W-1:0]         r_alu_op;
    logic [XLEN-1:0]         r_alu_v1;
    logic [XLEN-1:0]         r_alu_v2;
    rob_tag_t                r_alu_rob_id;

    logic [RS_SIZE-1:0]      w_busy;
    logic [RS_SIZE-1:0]      w_ready;
    logic                    w_full;
    logic                    w_free_found;
    logic [RS_IDX_W-1:0]     w_free_idx;
    logic                    w_issue_found;
    logic [RS_IDX_W-1:0]     w_issue_idx;
    logic                    w_alloc;
    rs_entry_t               w_new_entry;

    generate
        for (genvar g = 0; g < RS_SIZE; g++) begin : g_vec
            assign w_busy[g]  = r_entries[g].busy;
            assign w_ready[g] = r_entries[g].busy && !r_entries[g].src1.busy
                                && !r_entries[g].src2.busy;
        end
    endgenerate

    assign w_full = &w_busy;

    alu_rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
        .req   (~w_busy),
        .found (w_free_found),
        .idx   (w_free_idx)
    );

    alu_rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_sel (
        .req   (w_ready),
        .found (w_issue_found),
        .idx   (w_issue_idx)
    );

    // An issuing slot is still busy here, so allocation never lands on it.
    assign w_alloc = bus.disp_valid && !w_full && w_free_found;

    always_comb begin
        w_new_entry        = '0;
        w_new_entry.busy   = 1'b1;
        w_new_entry.op     = bus.disp_op;
        w_new_entry.rob_id = bus.disp_rob_id;
        w_new_entry.src1   = snoop('{busy: bus.disp_q1_busy, tag: bus.disp_q1, value: bus.disp_v1},
                                   bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_value,
                                   bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
        w_new_entry.src2   = snoop('{busy: bus.disp_q2_busy, tag: bus.disp_q2, value: bus.disp_v2},
                                   bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_value,
                                   bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entries[i] <= '0;
            end
            r_alu_valid  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_v1     <= '0;
            r_alu_v2     <= '0;
            r_alu_rob_id <= '0;
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_entries[i].busy <= 1'b0;
                end
                r_alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_entries[i].busy) begin
                        r_entries[i].src1 <= snoop(r_entries[i].src1,
                            bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
                        r_entries[i].src2 <= snoop(r_entries[i].src2,
                            bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
                    end
                end
                if (w_issue_found) begin
                    r_alu_valid                  <= 1'b1;
                    r_alu_op                     <= r_entries[w_issue_idx].op;
                    r_alu_v1                     <= r_entries[w_issue_idx].src1.value;
                    r_alu_v2                     <= r_entries[w_issue_idx].src2.value;
                    r_alu_rob_id                 <= r_entries[w_issue_idx].rob_id;
                    r_entries[w_issue_idx].busy  <= 1'b0;
                end else begin
                    r_alu_valid <= 1'b0;
                end
                if (w_alloc) begin
                    r_entries[w_free_idx] <= w_new_entry;
                end
            end
        end
    end

    assign bus.rs_full    = w_full;
    assign bus.alu_valid  = r_alu_valid;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_v1     = r_alu_v1;
    assign bus.alu_v2     = r_alu_v2;
    assign bus.alu_rob_id = r_alu_rob_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
//============================================================================
// Module      : tb_alu_rs
// Description : Scoreboard bench for alu_rs: directed scenarios plus random
//               traffic checked against a slot-list reference model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    alu_rs_if bus ();

    alu_rs dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt = 0;
    bit   started = 1'b0;

    // Reference model: slot list with pending tags as ints (-1 = value present).
    bit          m_used [8];
    logic [4:0]  m_op   [8];
    logic [3:0]  m_rob  [8];
    logic [31:0] m_v1   [8];
    logic [31:0] m_v2   [8];
    int          m_p1   [8];
    int          m_p2   [8];
    bit          o_valid;
    exp_t        o_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic grab(inout int pend, inout logic [31:0] val);
        if (pend >= 0 && bus.cdb_alu_valid && int'(bus.cdb_alu_rob_id) == pend) begin
            val = bus.cdb_alu_value; pend = -1;
        end else if (pend >= 0 && bus.cdb_lsb_valid && int'(bus.cdb_lsb_rob_id) == pend) begin
            val = bus.cdb_lsb_value; pend = -1;
        end
    endtask

    function automatic int used_count();
        int n = 0;
        foreach (m_used[i]) n += m_used[i] ? 1 : 0;
        return n;
    endfunction

    // Applies the effect of the coming clock edge to the model.
    task automatic model_step();
        int sel, fr, p1, p2;
        logic [31:0] a, b;
        exp_t e;
        if (rst) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            o_valid = 1'b0;
            o_last  = '{0, 5'd0, 32'd0, 32'd0, 4'd0};
            started = 1'b1;
        end else if (!rdy) begin
            if (o_valid) begin
                e = o_last; e.edge_no = edge_cnt + 1; q.push_back(e);
            end
        end else if (clear) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            o_valid = 1'b0;
        end else begin
            sel = -1; fr = -1;
            for (int i = 0; i < 8; i++) begin
                if (sel < 0 && m_used[i] && m_p1[i] < 0 && m_p2[i] < 0) sel = i;
                if (fr < 0 && !m_used[i]) fr = i;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_used[i]) begin
                    p1 = m_p1[i]; a = m_v1[i]; grab(p1, a); m_p1[i] = p1; m_v1[i] = a;
                    p2 = m_p2[i]; b = m_v2[i]; grab(p2, b); m_p2[i] = p2; m_v2[i] = b;
                end
            end
            if (sel >= 0) begin
                e = '{edge_cnt + 1, m_op[sel], m_v1[sel], m_v2[sel], m_rob[sel]};
                q.push_back(e);
                o_last = e; o_valid = 1'b1; m_used[sel] = 1'b0;
            end else begin
                o_valid = 1'b0;
            end
            if (bus.disp_valid && fr >= 0) begin
                p1 = bus.disp_q1_busy ? int'(bus.disp_q1) : -1; a = bus.disp_v1; grab(p1, a);
                p2 = bus.disp_q2_busy ? int'(bus.disp_q2) : -1; b = bus.disp_v2; grab(p2, b);
                m_used[fr] = 1'b1; m_op[fr] = bus.disp_op; m_rob[fr] = bus.disp_rob_id;
                m_v1[fr] = a; m_v2[fr] = b; m_p1[fr] = p1; m_p2[fr] = p2;
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        edge_cnt++;
        if (started) begin
            if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
                e = q.pop_front();
                chk("issue_valid", 32'(bus.alu_valid), 32'd1);
                chk("issue_op",    32'(bus.alu_op),    32'(e.op));
                chk("issue_v1",    bus.alu_v1,         e.v1);
                chk("issue_v2",    bus.alu_v2,         e.v2);
                chk("issue_rob",   32'(bus.alu_rob_id), 32'(e.rob));
            end else begin
                chk("idle_valid",  32'(bus.alu_valid), 32'd0);
                chk("hold_op",     32'(bus.alu_op),    32'(o_last.op));
                chk("hold_v1",     bus.alu_v1,         o_last.v1);
                chk("hold_v2",     bus.alu_v2,         o_last.v2);
                chk("hold_rob",    32'(bus.alu_rob_id), 32'(o_last.rob));
            end
            chk("rs_full", 32'(bus.rs_full), (used_count() == 8) ? 32'd1 : 32'd0);
        end
    end

    task automatic set_idle();
        rdy = 1'b1; clear = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_rob_id = '0;
        bus.disp_v1 = '0; bus.disp_v2 = '0;
        bus.disp_q1_busy = 1'b0; bus.disp_q2_busy = 1'b0; bus.disp_q1 = '0; bus.disp_q2 = '0;
        bus.cdb_alu_valid = 1'b0; bus.cdb_alu_rob_id = '0; bus.cdb_alu_value = '0;
        bus.cdb_lsb_valid = 1'b0; bus.cdb_lsb_rob_id = '0; bus.cdb_lsb_value = '0;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        set_idle();
    endtask

    task automatic disp(input logic [4:0] op, input logic [3:0] rob, input logic [31:0] v1,
                        input logic [31:0] v2, input logic q1b, input logic [3:0] q1,
                        input logic q2b, input logic [3:0] q2);
        bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_rob_id = rob;
        bus.disp_v1 = v1; bus.disp_v2 = v2;
        bus.disp_q1_busy = q1b; bus.disp_q1 = q1; bus.disp_q2_busy = q2b; bus.disp_q2 = q2;
    endtask

    task automatic cdb_a(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_alu_valid = 1'b1; bus.cdb_alu_rob_id = tag; bus.cdb_alu_value = val;
    endtask

    task automatic cdb_l(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_lsb_valid = 1'b1; bus.cdb_lsb_rob_id = tag; bus.cdb_lsb_value = val;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Simple ready op, then idle.
        disp(5'b00000, 4'd2, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        tick(); tick();

        // Wake-up through the LSB bus.
        disp(5'b01000, 4'd1, 32'd0, 32'd7, 1'b1, 4'd5, 1'b0, 4'd0); tick();
        tick();
        cdb_l(4'd5, 32'h10); tick();
        tick(); tick();

        // Capture in the dispatch cycle, and ALU-over-LSB priority.
        disp(5'b10101, 4'd6, 32'd11, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3); cdb_a(4'd3, 32'd9); tick();
        disp(5'b00011, 4'd7, 32'd0, 32'd1, 1'b1, 4'd4, 1'b0, 4'd0);
        cdb_a(4'd4, 32'hAA); cdb_l(4'd4, 32'hBB); tick();
        tick(); tick();

        // Fill all slots, overflow dispatch, free one, refill.
        for (int i = 0; i < 8; i++) begin
            disp(5'(i), 4'(i), 32'(i), 32'(100 + i), 1'b1, 4'(8 + i), 1'b0, 4'd0); tick();
        end
        disp(5'd31, 4'd15, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        cdb_l(4'd10, 32'h222); tick();
        tick();
        disp(5'd17, 4'd12, 32'h5, 32'h6, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        // Entries 1 and 4 ready together: lower index first.
        cdb_a(4'd9, 32'h111); cdb_l(4'd12, 32'h444); tick();
        tick(); tick(); tick();

        // Freeze for two cycles, then flush with a simultaneous dispatch.
        rdy = 1'b0; cdb_a(4'd8, 32'h1); tick();
        rdy = 1'b0; disp(5'd1, 4'd1, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        clear = 1'b1; disp(5'd2, 4'd2, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        tick(); tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6)
                disp(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 4) cdb_a(4'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 9) < 4) cdb_l(4'($urandom_range(0, 7)), $urandom);
            tick();
        end

        clear = 1'b1; tick();
        tick(); tick();
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station and issue scheduler for the integer ALU in the Tomasulo out-of-order core.
- Accepts decoded ALU/branch ops from dispatch and holds them until both operands are available.
- Snoops two result broadcast buses (ALU, LSB) for operand wake-up.
- Issues at most one ready op per cycle to the ALU, oldest-slot-first by lowest index.

Parameters:
RS_SIZE, 8, number of entries (power of two)
RS_IDX_W, 3, log2(RS_SIZE)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
clear  in  1  mispredict flush, synchronous
disp_valid  in  1  dispatch request this cycle
disp_op  in  5  ALU op code (bit4 = branch compare, bit3 = sub/sra, [2:0] = funct3)
disp_rob_id  in  ROB_SIZE_WIDTH  destination ROB tag
disp_v1, disp_v2  in  32 each  operand values, valid when matching q*_busy = 0
disp_q1_busy, disp_q2_busy  in  1 each  operand still pending
disp_q1, disp_q2  in  ROB_SIZE_WIDTH each  producer ROB tags
cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value  in  1/ROB_SIZE_WIDTH/32  ALU broadcast
cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value  in  1/ROB_SIZE_WIDTH/32  LSB broadcast
rs_full  out  1  no free entry (combinational from registered state)
alu_valid  out  1  issue strobe to ALU
alu_op  out  5  issued op
alu_v1, alu_v2  out  32 each  issued operands
alu_rob_id  out  ROB_SIZE_WIDTH  issued tag

Behaviour:
- Priority: rst > !rdy (hold everything) > clear > normal operation.
- Reset: all entries invalid; alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id = 0; rs_full = 0.
- clear: all entries invalid, alu_valid <= 0; dispatch in the same cycle is dropped.
- Per-entry state: busy, op, rob_id, v1, v2, q1, q2, q1_busy, q2_busy.
- Allocate: when disp_valid && !rs_full, write the lowest-index free entry.
- Dispatch while rs_full is a protocol violation; the request is ignored and no state changes.
- Dispatch-time capture: if disp_qN_busy and a CDB is valid this cycle with rob_id == disp_qN, store the broadcast value and set qN_busy = 0.
- Wake-up: each cycle, every busy entry with qN_busy and a matching valid CDB tag latches the value and clears qN_busy.
- ALU CDB wins if both buses carry the same tag (illegal case, but deterministic).
- Select: lowest-index entry with busy && !q1_busy && !q2_busy, evaluated on registered state only.
  - An entry written or woken at edge E becomes issuable for selection at edge E+1.
- Issue at edge E: alu_* registered from the selected entry, alu_valid <= 1, entry busy <= 0.
  - The freed slot is visible to rs_full/allocation after E.
  - No candidate: alu_valid <= 0; other alu_* outputs hold their last values.
- Latency: dispatch with both operands ready at edge E0 -> alu_valid high after E1 -> ALU result after E2.
- Issue and allocation in the same cycle both proceed, to different slots.
- Allocation never targets a slot being freed this cycle.
- rs_full = all RS_SIZE entries busy.
- Tag compares are exact ROB_SIZE_WIDTH equality; no wrap handling needed (ROB tags are unique while in flight).

Decomposition:
- ROB_SIZE_WIDTH, RS_SIZE, and op-field positions (branch bit 4, alt bit 3, funct3 [2:0]) live in shared config.v.
- One sub-module: rs_select, a combinational lowest-index priority encoder.
  - Used twice: free-slot search and ready-entry search.
  - Outputs: found, index.

Test Plan:
1. Dispatch op=5'b00000, v1=3, v2=4, no deps, rob_id=2 -> after E1 alu_valid=1, alu_op=0, alu_v1=3, alu_v2=4, alu_rob_id=2; next cycle alu_valid=0.
2. Dependency wake-up: dispatch q1_busy=1, q1=5, v2=7 -> no issue; cdb_lsb_valid with rob_id=5, value=0x10 at edge Ek -> issue at Ek+1 with alu_v1=0x10, alu_v2=7.
3. Same-cycle capture: dispatch q2=3 while cdb_alu_valid, rob_id=3, value=9 -> entry stored ready; issue next edge with alu_v2=9.
4. Fill: 8 dispatches, all with q1 pending -> rs_full=1, 9th dispatch ignored; wake one entry -> issued, rs_full drops, next dispatch lands in freed index.
5. Ordering: entries 1 and 4 become ready the same cycle -> entry 1 issues first, entry 4 on the following cycle.
6. clear with 3 busy entries plus simultaneous dispatch -> all entries empty, alu_valid=0, rs_full=0; rdy=0 for 2 cycles mid-stream -> outputs and entries unchanged.
